// File: rtl/pdm_decoder.sv
// 1-bit PDM to 16-bit level decoder: 2-flop synchroniser, sinc2 CIC decimator
// by 2**DECIM_LOG2, two-event warm-up, and saturating scale to 16-bit full scale.
module pdm_decoder #(
  parameter int DECIM_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pdm_in,
  input  logic        sample_en,
  output logic [15:0] level,
  output logic        level_valid,
  output logic        clipped,
  output logic [1:0]  dbg_state
);

  localparam int W     = 2 * DECIM_LOG2 + 1;
  localparam int SHIFT = 2 * (8 - DECIM_LOG2);
  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [W-1:0]          i1_q, i1_d;
  logic [W-1:0]          i2_q, i2_d;
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic                  dec_event;

  logic [W-1:0]          snap_q, snap_d;
  logic                  snap_vld_q, snap_vld_d;
  logic                  snap_emit_q, snap_emit_d;

  logic [W-1:0]          s_prev_q, s_prev_d;
  logic [W-1:0]          c1_prev_q, c1_prev_d;
  logic [W-1:0]          c1, y;
  logic [W-1:0]          y_q, y_d;
  logic                  y_emit_q, y_emit_d;

  logic [16:0]           v;
  logic [15:0]           level_q, level_d;
  logic                  level_valid_q, level_valid_d;
  logic                  clipped_q, clipped_d;

  // Synchroniser and integrators; everything but the sync chain freezes
  // while sample_en is low.
  always_comb begin
    sync1_d   = pdm_in;
    sync2_d   = sync1_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    phase_d   = phase_q;
    dec_event = 1'b0;
    if (sample_en) begin
      i1_d      = i1_q + W'(sync2_q);
      i2_d      = i2_q + i1_q;
      phase_d   = phase_q + DECIM_LOG2'(1);
      dec_event = (phase_q == PHASE_LAST);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WARM0:   if (dec_event) state_d = WARM1;
      WARM1:   if (dec_event) state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  // Snapshot holds the post-update i2; the emit decision is taken here so a
  // later state change cannot affect a result already in flight.
  always_comb begin
    snap_d      = snap_q;
    snap_vld_d  = dec_event;
    snap_emit_d = dec_event && (state_q == RUN);
    if (dec_event) snap_d = i2_d;
  end

  // Comb section runs on every event, including warm-up, so its history
  // registers are primed by the time output is enabled.
  always_comb begin
    c1        = snap_q - s_prev_q;
    y         = c1 - c1_prev_q;
    s_prev_d  = s_prev_q;
    c1_prev_d = c1_prev_q;
    y_d       = y_q;
    y_emit_d  = 1'b0;
    if (snap_vld_q) begin
      s_prev_d  = snap_q;
      c1_prev_d = c1;
      y_d       = y;
      y_emit_d  = snap_emit_q;
    end
  end

  // level_valid is a one-cycle strobe with no back-pressure: the consumer
  // must capture level/clipped in the cycle level_valid is high.
  always_comb begin
    v             = 17'(y_q) << SHIFT;
    level_d       = level_q;
    level_valid_d = 1'b0;
    clipped_d     = 1'b0;
    if (y_emit_q) begin
      level_valid_d = 1'b1;
      if (v[16]) begin
        level_d   = 16'hFFFF;
        clipped_d = 1'b1;
      end else begin
        level_d = v[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= WARM0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      i1_q          <= '0;
      i2_q          <= '0;
      phase_q       <= '0;
      snap_q        <= '0;
      snap_vld_q    <= 1'b0;
      snap_emit_q   <= 1'b0;
      s_prev_q      <= '0;
      c1_prev_q     <= '0;
      y_q           <= '0;
      y_emit_q      <= 1'b0;
      level_q       <= 16'h0000;
      level_valid_q <= 1'b0;
      clipped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      i1_q          <= i1_d;
      i2_q          <= i2_d;
      phase_q       <= phase_d;
      snap_q        <= snap_d;
      snap_vld_q    <= snap_vld_d;
      snap_emit_q   <= snap_emit_d;
      s_prev_q      <= s_prev_d;
      c1_prev_q     <= c1_prev_d;
      y_q           <= y_d;
      y_emit_q      <= y_emit_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      clipped_q     <= clipped_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign clipped     = clipped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench for pdm_decoder at DECIM_LOG2=8 and DECIM_LOG2=4, with a small
// event-timing model predicting when level_valid must pulse.
module tb_pdm_decoder;

  logic        clk;
  logic        rst8_n, pdm8, en8;
  logic [15:0] level8;
  logic        valid8, clip8;
  logic [1:0]  st8;
  logic        rst4_n, pdm4, en4;
  logic [15:0] level4;
  logic        valid4, clip4;
  logic [1:0]  st4;

  int checks = 0;
  int errors = 0;

  // Timing model: accepted-sample phase, event count, emit flags of the two
  // previous edges.
  int m_phase;
  int m_events;
  bit m_e1, m_e2;

  pdm_decoder #(.DECIM_LOG2(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .pdm_in(pdm8), .sample_en(en8),
    .level(level8), .level_valid(valid8), .clipped(clip8), .dbg_state(st8)
  );

  pdm_decoder #(.DECIM_LOG2(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .pdm_in(pdm4), .sample_en(en4),
    .level(level4), .level_valid(valid4), .clipped(clip4), .dbg_state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_phase  = 0;
    m_events = 0;
    m_e1     = 1'b0;
    m_e2     = 1'b0;
  endtask

  // Call once per edge with rst_n high; exp_v is the level_valid expected now.
  task automatic m_step(input int r, input bit acc, output bit exp_v);
    exp_v = m_e2;
    m_e2  = m_e1;
    m_e1  = 1'b0;
    if (acc) begin
      if (m_phase == r - 1) begin
        if (m_events >= 2) m_e1 = 1'b1;
        m_events++;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic test_reset();
    rst8_n = 1'b0; rst4_n = 1'b0;
    pdm8 = 1'b1; pdm4 = 1'b1; en8 = 1'b1; en4 = 1'b1;
    clk_tick();
    clk_tick();
    checks++; if (level8 !== 16'h0000) begin errors++; $display("FAIL reset_level8: got %h want 0000", level8); end
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", valid8); end
    checks++; if (clip8 !== 1'b0) begin errors++; $display("FAIL reset_clip8: got %b want 0", clip8); end
    checks++; if (st8 !== 2'd0) begin errors++; $display("FAIL reset_state8: got %0d want 0", st8); end
    checks++; if (level4 !== 16'h0000) begin errors++; $display("FAIL reset_level4: got %h want 0000", level4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", valid4); end
    checks++; if (clip4 !== 1'b0) begin errors++; $display("FAIL reset_clip4: got %b want 0", clip4); end
    checks++; if (st4 !== 2'd0) begin errors++; $display("FAIL reset_state4: got %0d want 0", st4); end
    en8 = 1'b0; en4 = 1'b0;
  endtask

  task automatic test_const_one();
    bit ev;
    int seen;
    logic [15:0] held;
    seen = 0; held = 16'h0000;
    pdm8 = 1'b1; en8 = 1'b1; rst8_n = 1'b0;
    clk_tick();
    rst8_n = 1'b1; m_reset();
    for (int c = 0; c < 6 * 256; c++) begin
      clk_tick();
      m_step(256, en8, ev);
      if (ev) held = 16'hFFFF;
      if (valid8 === 1'b1) seen++;
      checks++;
      if (valid8 !== ev || level8 !== held || clip8 !== ev) begin
        errors++;
        $display("FAIL const_one cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=%b",
                 c, valid8, level8, clip8, ev, held, ev);
      end
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL const_one_count: got %0d pulses want 3", seen); end
    checks++; if (st8 !== 2'd2) begin errors++; $display("FAIL const_one_state: got %0d want 2", st8); end
    en8 = 1'b0;
  endtask

  task automatic test_const_zero();
    bit ev;
    int seen;
    seen = 0;
    pdm8 = 1'b0; en8 = 1'b1; rst8_n = 1'b0;
    clk_tick();
    rst8_n = 1'b1; m_reset();
    for (int c = 0; c < 5 * 256; c++) begin
      clk_tick();
      m_step(256, en8, ev);
      if (valid8 === 1'b1) seen++;
      checks++;
      if (valid8 !== ev || level8 !== 16'h0000 || clip8 !== 1'b0) begin
        errors++;
        $display("FAIL const_zero cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=0000 clipped=0",
                 c, valid8, level8, clip8, ev);
      end
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL const_zero_count: got %0d pulses want 2", seen); end
    en8 = 1'b0;
  endtask

  // Alternating input, both starting polarities.
  task automatic test_alternating();
    bit ev;
    logic [15:0] held;
    for (int s = 0; s < 2; s++) begin
      held = 16'h0000;
      pdm8 = (s == 1); en8 = 1'b1; rst8_n = 1'b0;
      clk_tick();
      rst8_n = 1'b1; m_reset();
      for (int c = 0; c < 1100; c++) begin
        pdm8 = ~pdm8;
        clk_tick();
        m_step(256, en8, ev);
        if (ev) held = 16'h8000;
        checks++;
        if (valid8 !== ev || level8 !== held || clip8 !== 1'b0) begin
          errors++;
          $display("FAIL alternating start %0d cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=0",
                   s, c, valid8, level8, clip8, ev, held);
        end
      end
    end
    en8 = 1'b0;
  endtask

  // sample_en high one cycle in three; pulses must be 48 cycles apart.
  task automatic test_sparse_enable();
    bit ev;
    int last;
    logic [15:0] held;
    held = 16'h0000; last = -1;
    pdm4 = 1'b1; en4 = 1'b0; rst4_n = 1'b0;
    clk_tick();
    rst4_n = 1'b1; m_reset();
    for (int c = 0; c < 300; c++) begin
      en4 = (c % 3 == 0);
      clk_tick();
      m_step(16, en4, ev);
      if (ev) held = 16'hFFFF;
      checks++;
      if (valid4 !== ev || level4 !== held || clip4 !== ev) begin
        errors++;
        $display("FAIL sparse cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=%b",
                 c, valid4, level4, clip4, ev, held, ev);
      end
      if (valid4 === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 48) begin errors++; $display("FAIL sparse_interval: got %0d cycles want 48", c - last); end
        end
        last = c;
      end
    end
    en4 = 1'b0;
  endtask

  // Over 10+ emitted events, level_valid lands exactly 2 edges after phase R-1.
  task automatic test_latency();
    bit ev;
    int seen;
    logic [15:0] held;
    held = 16'h0000; seen = 0;
    pdm4 = 1'b0; en4 = 1'b1; rst4_n = 1'b0;
    clk_tick();
    rst4_n = 1'b1; m_reset();
    for (int c = 0; c < 14 * 16; c++) begin
      pdm4 = ~pdm4;
      clk_tick();
      m_step(16, en4, ev);
      if (ev) held = 16'h8000;
      if (valid4 === 1'b1) seen++;
      checks++;
      if (valid4 !== ev || level4 !== held || clip4 !== 1'b0) begin
        errors++;
        $display("FAIL latency cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=0",
                 c, valid4, level4, clip4, ev, held);
      end
    end
    checks++; if (seen < 10) begin errors++; $display("FAIL latency_count: got %0d pulses want >= 10", seen); end
    en4 = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    bit ev;
    logic [15:0] held;
    held = 16'h0000;
    pdm8 = 1'b1; en8 = 1'b1; rst8_n = 1'b0;
    clk_tick();
    rst8_n = 1'b1; m_reset();
    for (int c = 0; c < 3 * 256 + 100; c++) begin
      clk_tick();
      m_step(256, en8, ev);
      if (ev) held = 16'hFFFF;
    end
    checks++; if (level8 !== 16'hFFFF) begin errors++; $display("FAIL midwin_pre: level got %h want ffff", level8); end
    rst8_n = 1'b0;
    clk_tick();
    checks++;
    if (level8 !== 16'h0000 || valid8 !== 1'b0 || clip8 !== 1'b0 || st8 !== 2'd0) begin
      errors++;
      $display("FAIL midwin_reset: level=%h valid=%b clipped=%b state=%0d, want 0000 0 0 0", level8, valid8, clip8, st8);
    end
    rst8_n = 1'b1; m_reset(); held = 16'h0000;
    for (int c = 0; c < 3 * 256 + 10; c++) begin
      clk_tick();
      m_step(256, en8, ev);
      if (ev) held = 16'hFFFF;
      checks++;
      if (valid8 !== ev || level8 !== held || clip8 !== ev) begin
        errors++;
        $display("FAIL midwin_after cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=%b",
                 c, valid8, level8, clip8, ev, held, ev);
      end
    end
    en8 = 1'b0;
  endtask

  // Reset lands on the edge right after an emitting event: that result is dropped.
  task automatic test_reset_in_flight();
    bit ev;
    bit hit;
    logic [15:0] held;
    hit = 1'b0;
    pdm4 = 1'b1; en4 = 1'b1; rst4_n = 1'b0;
    clk_tick();
    rst4_n = 1'b1; m_reset();
    for (int c = 0; c < 200 && !hit; c++) begin
      clk_tick();
      m_step(16, en4, ev);
      hit = m_e1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL inflight_setup: no emitting event within 200 cycles"); end
    rst4_n = 1'b0;
    clk_tick();
    checks++;
    if (level4 !== 16'h0000 || valid4 !== 1'b0 || clip4 !== 1'b0) begin
      errors++;
      $display("FAIL inflight_reset: level=%h valid=%b clipped=%b, want 0000 0 0", level4, valid4, clip4);
    end
    rst4_n = 1'b1; m_reset(); held = 16'h0000;
    for (int c = 0; c < 3 * 16 + 20; c++) begin
      clk_tick();
      m_step(16, en4, ev);
      if (ev) held = 16'hFFFF;
      checks++;
      if (valid4 !== ev || level4 !== held || clip4 !== ev) begin
        errors++;
        $display("FAIL inflight_after cycle %0d: valid=%b level=%h clipped=%b, want valid=%b level=%h clipped=%b",
                 c, valid4, level4, clip4, ev, held, ev);
      end
    end
    en4 = 1'b0;
  endtask

  initial begin
    rst8_n = 1'b0; rst4_n = 1'b0;
    pdm8 = 1'b0; pdm4 = 1'b0; en8 = 1'b0; en4 = 1'b0;
    m_reset();
    test_reset();
    test_const_one();
    test_const_zero();
    test_alternating();
    test_sparse_enable();
    test_latency();
    test_reset_mid_window();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_decoder.md
PDM_DECODER -- requirements
Module: pdm_decoder

Interface
REQ-001 Parameter DECIM_LOG2, default 8, log2 of decimation ratio R; legal range 4..8.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pdm_in  input  1  asynchronous 1-bit pulse-density stream.
REQ-005 sample_en  input  1  when high, the current synchronised bit is accepted as one sample.
REQ-006 level  output  16  decoded level, unsigned; full scale 0xFFFF.
REQ-007 level_valid  output  1  single-cycle pulse marking a new level value.
REQ-008 clipped  output  1  high together with level_valid when the value was saturated; otherwise 0.

Function
REQ-009 pdm_in SHALL pass through a 2-flop synchroniser; sample x is the second flop's output at the accepting edge.
REQ-010 Filter SHALL be a 2nd-order CIC (sinc2), differential delay 1, W = 2*DECIM_LOG2+1 bit registers, modular (wrap-around) arithmetic.
REQ-011 Per accepted sample: i1 <= i1 + x; i2 <= i2 + i1 (previous i1); no state changes when sample_en=0.
REQ-012 A phase counter 0..R-1 SHALL advance per accepted sample and wrap R-1 -> 0; acceptance at phase R-1 is a decimation event.
REQ-013 At a decimation event, i2 (including that sample) SHALL be snapshotted; on the next clk the comb computes c1 = s - s_prev, y = c1 - c1_prev, and updates s_prev, c1_prev.
REQ-014 y SHALL equal the triangle-weighted (1,2..R..2,1) sum of the last 2R-1 accepted samples; constant 1 gives y = R*R.
REQ-015 Scaling: v = y << 2*(8-DECIM_LOG2); if v >= 65536 then level = 0xFFFF and clipped = 1, else level = v[15:0], clipped = 0.
REQ-016 level, clipped and level_valid SHALL update exactly 2 clk cycles after the edge accepting the decimation sample; level holds between updates.
REQ-017 Control FSM states: WARM0 -> WARM1 -> RUN, one transition per decimation event; level_valid/level/clipped updates suppressed in WARM0 and WARM1, enabled in RUN; RUN is absorbing.
REQ-018 First emitted value SHALL be from the 3rd decimation event after reset.
REQ-019 sample_en deasserted during the 2-cycle comb/output pipeline SHALL NOT stall or corrupt that output.
REQ-020 Decimation events are at least R cycles apart, so the pipeline never overlaps itself.

Reset
REQ-021 When rst_n=0 at a clk edge: sync flops, i1, i2, comb registers, phase = 0, FSM = WARM0, level = 0x0000, level_valid = 0, clipped = 0.
REQ-022 Reset mid-window SHALL discard the partial window and in-flight pipeline result; warm-up restarts (REQ-018).
REQ-023 Reset SHALL take priority over sample_en and pending pipeline updates in the same cycle.

Verification
REQ-024 DECIM_LOG2=8, sample_en=1, pdm_in=1 constant -> from 3rd event on, level=0xFFFF, clipped=1, level_valid every 256 cycles.
REQ-025 pdm_in=0 constant -> level=0x0000, clipped=0, level_valid every 256 cycles.
REQ-026 pdm_in alternating 1,0 each cycle -> every emitted level=0x8000 regardless of starting phase, clipped=0.
REQ-027 DECIM_LOG2=4, pdm_in=1, sample_en high 1 cycle in 3 -> level_valid every 48 cycles, level=0xFFFF, clipped=1; intervening sample_en=0 cycles change nothing.
REQ-028 Latency: level_valid asserts exactly 2 cycles after the edge accepting phase R-1, checked over 10 consecutive events.
REQ-029 rst_n low 1 cycle mid-window in RUN -> next cycle level=0, level_valid=0; no level_valid until 3rd decimation event after release.
